// File: rtl/tt_pkg.sv
// Shared types and constants for the truth-table sequencer.
package tt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    DONE
  } state_t;

  localparam int unsigned SETTLE_W = 4;

  function automatic int unsigned tt_width(input int unsigned n);
    return 32'd1 << n;
  endfunction

endpackage

// File: rtl/tt_settle_timer.sv
// Settle counter: counts enabled cycles and flags the last one of each
// SETTLE-cycle window, wrapping to zero on that cycle.
module tt_settle_timer
  import tt_pkg::*;
#(
  parameter int unsigned SETTLE = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic terminal
);

  logic [SETTLE_W-1:0] count;

  assign terminal = (count == SETTLE_W'(SETTLE - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= terminal ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/truth_table_sequencer.sv
// Steps a stimulus vector through every combination and captures the
// function output into a truth table. Optional checker: TT_COMPARE_EN.
module truth_table_sequencer
  import tt_pkg::*;
#(
  parameter int unsigned N_IN   = 3,
  parameter int unsigned SETTLE = 2,
  localparam int unsigned W     = tt_width(N_IN)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  output logic [N_IN-1:0] dut_in,
  input  logic            dut_out,
  output logic            busy,
  output logic            done,
  output logic [W-1:0]    truth_table
`ifdef TT_COMPARE_EN
  ,
  input  logic [W-1:0]    expected,
  output logic            mismatch,
  output logic [N_IN-1:0] mismatch_idx
`endif
);

  state_t          state, state_next;
  logic [N_IN-1:0] index;
  logic            accept;
  logic            settled;
  logic            sample;
  logic            last;

  // start is only honoured outside a sweep; DONE restarts like IDLE.
  assign accept = start && (state != DRIVE);
  assign sample = (state == DRIVE) && settled;
  assign last   = (index == '1);

  tt_settle_timer #(.SETTLE(SETTLE)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (accept),
    .en       (state == DRIVE),
    .terminal (settled)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE, DONE: if (start) state_next = DRIVE;
      DRIVE:      if (sample && last) state_next = DONE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      index       <= '0;
      truth_table <= '0;
    end else if (accept) begin
      index       <= '0;
      truth_table <= '0;
    end else if (sample) begin
      truth_table[index] <= dut_out;
      if (!last) index <= index + 1'b1;
    end
  end

`ifdef TT_COMPARE_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mismatch     <= 1'b0;
      mismatch_idx <= '0;
    end else if (accept) begin
      mismatch     <= 1'b0;
      mismatch_idx <= '0;
    end else if (sample && !mismatch && (dut_out != expected[index])) begin
      mismatch     <= 1'b1;
      mismatch_idx <= index;
    end
  end
`endif

  assign dut_in = index;
  assign busy   = (state == DRIVE);
  assign done   = (state == DONE);

endmodule

// File: tb/tb_truth_table_sequencer.sv
// Directed and randomized sweeps of two sequencer instances (SETTLE=2 and
// SETTLE=1) driving a table-defined boolean function.
module tb_truth_table_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start0 = 1'b0;
  logic       start1 = 1'b0;
  logic [7:0] func_tbl = 8'h00;
  logic [7:0] exp_tbl = 8'h00;
  int         sel = 0;

  logic [2:0] dut_in0, dut_in1;
  logic       dut_out0, dut_out1;
  logic       busy0, busy1, done0, done1;
  logic [7:0] tt0, tt1;
  logic       mm0, mm1;
  logic [2:0] mmi0, mmi1;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // The function block under stimulus is any 3-input function given as a table.
  assign dut_out0 = func_tbl[dut_in0];
  assign dut_out1 = func_tbl[dut_in1];

  truth_table_sequencer #(.N_IN(3), .SETTLE(2)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .dut_in(dut_in0), .dut_out(dut_out0),
    .busy(busy0), .done(done0), .truth_table(tt0)
`ifdef TT_COMPARE_EN
    , .expected(exp_tbl), .mismatch(mm0), .mismatch_idx(mmi0)
`endif
  );

  truth_table_sequencer #(.N_IN(3), .SETTLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .dut_in(dut_in1), .dut_out(dut_out1),
    .busy(busy1), .done(done1), .truth_table(tt1)
`ifdef TT_COMPARE_EN
    , .expected(exp_tbl), .mismatch(mm1), .mismatch_idx(mmi1)
`endif
  );

`ifndef TT_COMPARE_EN
  assign mm0 = 1'b0; assign mm1 = 1'b0;
  assign mmi0 = 3'd0; assign mmi1 = 3'd0;
`endif

  logic       busy_s, done_s, mm_s;
  logic [2:0] dut_in_s, mmi_s;
  logic [7:0] tt_s;
  assign busy_s   = (sel != 0) ? busy1   : busy0;
  assign done_s   = (sel != 0) ? done1   : done0;
  assign dut_in_s = (sel != 0) ? dut_in1 : dut_in0;
  assign tt_s     = (sel != 0) ? tt1     : tt0;
  assign mm_s     = (sel != 0) ? mm1     : mm0;
  assign mmi_s    = (sel != 0) ? mmi1    : mmi0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Full sweep on instance s; extra start pulses at busy cycles dup_a/dup_b.
  task automatic sweep(input int s, input logic [7:0] f, input int dup_a, input int dup_b);
    int settle;
    int cycles;
    sel      = s;
    settle   = (s != 0) ? 1 : 2;
    func_tbl = f;
    @(negedge clk);
    if (s != 0) start1 = 1'b1; else start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0; start1 = 1'b0;
    check("table_cleared_on_start", {24'd0, tt_s}, 32'd0);
    check("mismatch_cleared_on_start", {31'd0, mm_s}, 32'd0);
    cycles = 0;
    while (busy_s === 1'b1 && cycles < 64) begin
      check("dut_in_sequence", {29'd0, dut_in_s}, cycles / settle);
      check("done_low_while_busy", {31'd0, done_s}, 32'd0);
      cycles++;
      if (cycles == dup_a || cycles == dup_b) begin
        if (s != 0) start1 = 1'b1; else start0 = 1'b1;
      end else begin
        start0 = 1'b0; start1 = 1'b0;
      end
      @(negedge clk);
    end
    start0 = 1'b0; start1 = 1'b0;
    check("busy_cycle_count", cycles, 8 * settle);
    check("done_after_sweep", {31'd0, done_s}, 32'd1);
    check("busy_after_sweep", {31'd0, busy_s}, 32'd0);
    check("truth_table", {24'd0, tt_s}, {24'd0, f});
    check("dut_in_holds_last", {29'd0, dut_in_s}, 32'd7);
    @(negedge clk);
    check("done_held", {31'd0, done_s}, 32'd1);
    check("table_held", {24'd0, tt_s}, {24'd0, f});
  endtask

  // Expected checker result: lowest index where captured and expected tables differ.
  task automatic check_compare(input logic [7:0] f, input logic [7:0] e);
    logic [7:0] diff;
    logic       exp_mm;
    int         exp_idx;
    diff    = f ^ e;
    exp_mm  = (diff != 8'd0);
    exp_idx = 0;
    for (int i = 7; i >= 0; i--) if (diff[i]) exp_idx = i;
    check("mismatch_flag", {31'd0, mm_s}, {31'd0, exp_mm});
    if (exp_mm) check("mismatch_idx", {29'd0, mmi_s}, exp_idx);
  endtask

  initial begin
    int waited;
    logic [7:0] r;

    #1;
    check("reset_busy", {30'd0, busy1, busy0}, 32'd0);
    check("reset_done", {30'd0, done1, done0}, 32'd0);
    check("reset_table", {16'd0, tt1, tt0}, 32'd0);
    check("reset_dut_in", {26'd0, dut_in1, dut_in0}, 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    sweep(0, 8'h96, 0, 0);            // parity, SETTLE=2
    sweep(1, 8'h80, 0, 0);            // AND3, SETTLE=1
    sweep(0, 8'h96, 3, 9);            // restart attempts mid-sweep
    sweep(0, 8'hFE, 0, 0);            // OR3, started from DONE

    // Asynchronous abort while index 5 is being driven.
    sel = 0; func_tbl = 8'h96;
    @(negedge clk); start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    waited = 0;
    while (dut_in0 !== 3'd5 && waited < 40) begin
      @(negedge clk); waited++;
    end
    check("reached_index5", {29'd0, dut_in0}, 32'd5);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", {31'd0, busy0}, 32'd0);
    check("abort_done", {31'd0, done0}, 32'd0);
    check("abort_table", {24'd0, tt0}, 32'd0);
    check("abort_dut_in", {29'd0, dut_in0}, 32'd0);
    @(negedge clk); rst = 1'b0;
    sweep(0, 8'h96, 0, 0);

    for (int k = 0; k < 4; k++) begin
      r = 8'($urandom);
      sweep(k % 2, r, 0, 0);
    end

`ifdef TT_COMPARE_EN
    exp_tbl = 8'h96;
    sweep(0, 8'h96 ^ 8'h44, 0, 0);    // parity wrong at 2 and 6
    check_compare(8'h96 ^ 8'h44, exp_tbl);
    sweep(0, 8'h96, 0, 0);
    check_compare(8'h96, exp_tbl);
    for (int k = 0; k < 4; k++) begin
      exp_tbl = 8'($urandom);
      r = exp_tbl ^ ((k == 3) ? 8'h00 : 8'($urandom_range(1, 255)));
      sweep(k % 2, r, 0, 0);
      check_compare(r, exp_tbl);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
